// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWdata,
    StWack,
    StRdata,
    StMack,
    StStop
  } i2c_state_e;

  localparam int unsigned MAX_BYTES_DEFAULT = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command/status handshake between a requester and the I2C master controller.
interface i2c_master_ctrl_if #(
  parameter int unsigned MAX_BYTES = i2c_pkg::MAX_BYTES_DEFAULT
) ();

  logic                      start;
  logic [6:0]                addr;
  logic                      rw;
  logic [3:0]                len;
  logic [MAX_BYTES-1:0][7:0] wdata;
  logic [MAX_BYTES-1:0][7:0] rdata;
  logic                      busy;
  logic                      done;
  logic                      nack;

  modport master (
    output start, addr, rw, len, wdata,
    input  rdata, busy, done, nack
  );

  modport slave (
    input  start, addr, rw, len, wdata,
    output rdata, busy, done, nack
  );

endinterface

// File: rtl/i2c_scl_gen.sv
// Quarter-phase timebase: tick marks the last clk cycle of each SCL quarter.
module i2c_scl_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] quarter,
  output logic       tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      quarter_q;
  logic            last;

  assign last    = (32'(cnt_q) == CLK_DIV - 1);
  assign tick    = en && last;
  assign quarter = quarter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (!en) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (last) begin
      cnt_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START, 7-bit address, up to MAX_BYTES data bytes, STOP.
// Optional I2C_MCTRL_DEBUG_EN exposes dbg_state and dbg_bit.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_master_ctrl_if.slave  cmd,
  output logic              SCL,
  inout  wire               SDA
`ifdef I2C_MCTRL_DEBUG_EN
  ,
  output logic [3:0]        dbg_state,
  output logic [2:0]        dbg_bit
`endif
);

  localparam int unsigned IdxW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  i2c_state_e                state_q;
  logic [2:0]                bit_q;
  logic [IdxW-1:0]           byte_q;
  logic [3:0]                len_q;
  logic [7:0]                addr_rw_q;
  logic [MAX_BYTES-1:0][7:0] wdata_q;
  logic [MAX_BYTES-1:0][7:0] rdata_q;
  logic                      samp_q;
  logic                      nack_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      scl_q;
  logic                      sda_oe_q;

  logic       scl_d;
  logic       sda_oe_d;
  logic [1:0] quarter;
  logic       tick;
  logic       last_byte;
  logic [3:0] len_clamped;
  logic       sda_in;

  i2c_scl_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_scl_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != StIdle),
    .quarter (quarter),
    .tick    (tick)
  );

  assign sda_in      = SDA;
  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL         = scl_q;
  assign last_byte   = (32'(byte_q) + 32'd1 >= 32'(len_q));
  assign len_clamped = (32'(cmd.len) > MAX_BYTES) ? 4'(MAX_BYTES) : cmd.len;

  assign cmd.rdata = rdata_q;
  assign cmd.busy  = busy_q;
  assign cmd.done  = done_q;
  assign cmd.nack  = nack_q;

`ifdef I2C_MCTRL_DEBUG_EN
  assign dbg_state = state_q;
  assign dbg_bit   = bit_q;
`endif

  // Bus levels for the current state/quarter; registered below so pins are glitch-free.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      StStart: begin
        scl_d    = (quarter != 2'd3);
        sda_oe_d = (quarter != 2'd0);
      end
      StAddr: begin
        scl_d    = quarter[1];
        sda_oe_d = ~addr_rw_q[3'd7 - bit_q];
      end
      StWdata: begin
        scl_d    = quarter[1];
        sda_oe_d = ~wdata_q[byte_q][3'd7 - bit_q];
      end
      StAddrAck, StWack, StRdata: begin
        scl_d = quarter[1];
      end
      StMack: begin
        scl_d    = quarter[1];
        sda_oe_d = ((last_byte ? NACK : ACK) == ACK);
      end
      StStop: begin
        scl_d    = quarter[1];
        sda_oe_d = (quarter != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_q     <= '0;
      byte_q    <= '0;
      len_q     <= '0;
      addr_rw_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      samp_q    <= 1'b1;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      if (state_q == StIdle) begin
        if (cmd.start) begin
          addr_rw_q <= {cmd.addr, cmd.rw};
          len_q     <= len_clamped;
          wdata_q   <= cmd.wdata;
          nack_q    <= 1'b0;
          busy_q    <= 1'b1;
          bit_q     <= '0;
          byte_q    <= '0;
          state_q   <= StStart;
        end
      end else if (tick) begin
        // The q1->q2 boundary edge is the one on which SCL rises.
        if (quarter == 2'd1) begin
          samp_q <= sda_in;
          if (state_q == StRdata) rdata_q[byte_q][3'd7 - bit_q] <= sda_in;
        end
        if (quarter == 2'd3) begin
          case (state_q)
            StStart: begin
              bit_q   <= '0;
              state_q <= StAddr;
            end
            StAddr: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= StAddrAck;
            end
            StAddrAck: begin
              bit_q  <= '0;
              byte_q <= '0;
              if (samp_q == NACK) begin
                nack_q  <= 1'b1;
                state_q <= StStop;
              end else if (len_q == 4'd0) begin
                state_q <= StStop;
              end else if (addr_rw_q[0]) begin
                state_q <= StRdata;
              end else begin
                state_q <= StWdata;
              end
            end
            StWdata: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= StWack;
            end
            StWack: begin
              bit_q <= '0;
              if (samp_q == NACK) begin
                nack_q  <= 1'b1;
                state_q <= StStop;
              end else if (last_byte) begin
                state_q <= StStop;
              end else begin
                byte_q  <= byte_q + 1'b1;
                state_q <= StWdata;
              end
            end
            StRdata: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= StMack;
            end
            StMack: begin
              bit_q <= '0;
              if (last_byte) begin
                state_q <= StStop;
              end else begin
                byte_q  <= byte_q + 1'b1;
                state_q <= StRdata;
              end
            end
            StStop: begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule
